ex_div: RTL and testbench

//  Iterative restoring divider for the EX stage: signed/unsigned DIV/DIVU, WIDTH-bit operands.
//  EX starts it and stalls the pipeline until ready_o; {remainder, quotient} goes to HI/LO.

---
 rtl/ex_div_pkg.sv | 25 ++
 rtl/ex_div.sv | 164 ++++++++++++++++
 tb/tb_ex_div.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage iterative divider: FSM state encodings,
// handshake levels and the ALU opcodes that select signed/unsigned division.
package ex_div_pkg;

    // Divider FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    // start_i levels driven by EX
    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    // ready_o levels
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // ALU opcodes EX decodes into start_i / signed_div_i
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider for the EX stage. Produces one quotient bit per
// clock on magnitudes, then fixes up signs in the final cycle. Result is
// {remainder, quotient} and is held while EX keeps start_i high.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Two's complement negation when neg is set; used both to take operand
    // magnitudes and to restore the signs of quotient and remainder.
    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                     input logic             neg);
        logic [WIDTH-1:0] one;
        one = {{(WIDTH-1){1'b0}}, 1'b1};
        return neg ? ((~v) + one) : v;
    endfunction

    div_state_t         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [2*WIDTH-1:0] result_nxt;
    logic               ready_nxt, busy_nxt;

    // Datapath: partial remainder is one bit wider than the divisor so the
    // shifted value (up to 2*divisor-1) never overflows before the compare.
    logic [WIDTH:0]     prem, prem_nxt;
    logic [WIDTH-1:0]   quo, quo_nxt;
    logic [WIDTH-1:0]   dvs, dvs_nxt;
    logic               sign_a, sign_a_nxt;
    logic               sign_b, sign_b_nxt;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               fits;

    // One restoring step: bring in the next dividend bit, try subtracting.
    assign shifted = {prem[WIDTH-1:0], quo[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, dvs});
    assign diff    = shifted - {1'b0, dvs};

    // Next-state, next-output and datapath update for the divider FSM
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        result_nxt = result_o;
        ready_nxt  = ready_o;
        busy_nxt   = busy_o;
        prem_nxt   = prem;
        quo_nxt    = quo;
        dvs_nxt    = dvs;
        sign_a_nxt = sign_a;
        sign_b_nxt = sign_b;

        case (state)
            DivFree: begin
                ready_nxt  = DivResultNotReady;
                busy_nxt   = 1'b0;
                result_nxt = '0;
                // annul_i wins over start_i: a flushed instruction never starts
                if (start_i == DivStart && !annul_i) begin
                    busy_nxt = 1'b1;
                    if (opdata2_i == '0) begin
                        state_nxt = DivByZero;
                    end else begin
                        state_nxt  = DivOn;
                        cnt_nxt    = '0;
                        prem_nxt   = '0;
                        sign_a_nxt = signed_div_i & opdata1_i[WIDTH-1];
                        sign_b_nxt = signed_div_i & opdata2_i[WIDTH-1];
                        quo_nxt    = cond_negate(opdata1_i, signed_div_i & opdata1_i[WIDTH-1]);
                        dvs_nxt    = cond_negate(opdata2_i, signed_div_i & opdata2_i[WIDTH-1]);
                    end
                end
            end

            DivByZero: begin
                busy_nxt = 1'b0;
                if (annul_i) begin
                    state_nxt = DivFree;
                end else begin
                    state_nxt  = DivEnd;
                    ready_nxt  = DivResultReady;
                    result_nxt = '0;
                end
            end

            DivOn: begin
                if (annul_i) begin
                    state_nxt = DivFree;
                    busy_nxt  = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    // Quotient negative iff signs differ; remainder follows dividend
                    state_nxt  = DivEnd;
                    busy_nxt   = 1'b0;
                    ready_nxt  = DivResultReady;
                    result_nxt = {cond_negate(prem[WIDTH-1:0], sign_a),
                                  cond_negate(quo, sign_a ^ sign_b)};
                end else begin
                    prem_nxt = fits ? diff : shifted;
                    quo_nxt  = {quo[WIDTH-2:0], fits};
                    cnt_nxt  = cnt + CNT_ONE;
                end
            end

            DivEnd: begin
                // Hold the result while EX stalls; release when it drops start_i
                if (annul_i || start_i == DivStop) begin
                    state_nxt  = DivFree;
                    ready_nxt  = DivResultNotReady;
                    result_nxt = '0;
                end
            end

            default: begin
                state_nxt  = DivFree;
                ready_nxt  = DivResultNotReady;
                busy_nxt   = 1'b0;
                result_nxt = '0;
            end
        endcase
    end

    // Control state and registered outputs; reset returns to an idle divider
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
            busy_o   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            result_o <= result_nxt;
            ready_o  <= ready_nxt;
            busy_o   <= busy_nxt;
        end
    end

    // Operand/working registers; only meaningful after a start is accepted
    always_ff @(posedge clk) begin
        prem   <= prem_nxt;
        quo    <= quo_nxt;
        dvs    <= dvs_nxt;
        sign_a <= sign_a_nxt;
        sign_b <= sign_b_nxt;
    end

endmodule

// File: tb/tb_ex_div.sv
// Directed and randomized checks of the EX-stage divider against a plain
// arithmetic reference (SystemVerilog / and % on the operands).
module tb_ex_div;

    localparam int WIDTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          signed_div;
    logic [31:0]   op1, op2;
    logic          start, annul;
    logic [63:0]   result;
    logic          ready, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_div #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .busy_o       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: truncating division, remainder carries the dividend's sign,
    // zero divisor yields zero; results truncated to WIDTH bits.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h8000_0000;
            5:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation and wait (bounded) for ready. n counts edges after
    // the accepting edge; busy_n counts samples with busy high before ready.
    // Operand inputs are scrambled after acceptance to prove they were captured.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] res, output int n, output int busy_n);
        signed_div = sgn;
        op1 = a;
        op2 = b;
        annul = 1'b0;
        start = 1'b1;
        tick();
        op1 = $urandom;
        op2 = $urandom;
        signed_div = ~sgn;
        n = 0;
        busy_n = 0;
        while (!ready && n < 100) begin
            if (busy) busy_n++;
            tick();
            n++;
        end
        res = result;
    endtask

    task automatic release_op();
        start = 1'b0;
        tick();
    endtask

    initial begin
        logic [63:0] res, held;
        int n, bn;
        logic sgn, seen;
        logic [31:0] a, b;

        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
        tick(); tick();
        check("rst_result", result, 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick();

        // DIVU 100/7 with latency and busy window
        run_div(1'b0, 32'd100, 32'd7, res, n, bn);
        check("divu_latency", 64'(n), 64'd33);
        check("divu_busy_cycles", 64'(bn), 64'd33);
        check("divu_100_7", res, {32'd2, 32'd14});
        check("divu_busy_at_end", 64'(busy), 64'd0);

        // Stall in END: result and ready hold
        held = res;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_ready", 64'(ready), 64'd1);
            check("stall_result", result, held);
        end
        release_op();
        check("release_ready", 64'(ready), 64'd0);
        check("release_result", result, 64'd0);

        // Signed sign-correction cases
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, res, n, bn);
        check("div_m7_2", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        release_op();
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, res, n, bn);
        check("div_7_m2", res, {32'd1, 32'hFFFF_FFFD});
        release_op();

        // Divide by zero fast path
        run_div(1'b1, 32'd5, 32'd0, res, n, bn);
        check("divzero_latency", 64'(n), 64'd1);
        check("divzero_result", res, 64'd0);
        check("divzero_ready", 64'(ready), 64'd1);
        release_op();

        // Signed overflow wraps
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, n, bn);
        check("div_overflow", res, {32'd0, 32'h8000_0000});
        release_op();

        // Annul 10 edges into ON
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1; annul = 1'b0;
        tick();
        repeat (10) tick();
        check("annul_pre_busy", 64'(busy), 64'd1);
        annul = 1'b1; start = 1'b0;
        tick();
        check("annul_busy", 64'(busy), 64'd0);
        check("annul_ready", 64'(ready), 64'd0);
        annul = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (ready || busy) seen = 1'b1;
        end
        check("annul_stays_idle", 64'(seen), 64'd0);
        run_div(1'b0, 32'd9, 32'd3, res, n, bn);
        check("after_annul_latency", 64'(n), 64'd33);
        check("after_annul_9_3", res, {32'd0, 32'd3});
        release_op();

        // start with annul in FREE does not start
        op1 = 32'd50; op2 = 32'd5; start = 1'b1; annul = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (ready || busy) seen = 1'b1;
        end
        check("annul_blocks_start", 64'(seen), 64'd0);
        start = 1'b0; annul = 1'b0;
        tick();

        // Reset 5 edges into ON
        signed_div = 1'b0; op1 = 32'd50; op2 = 32'd5; start = 1'b1;
        tick();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("midrst_result", result, 64'd0);
        check("midrst_ready", 64'(ready), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        check("midrst_idle", 64'(busy), 64'd0);
        run_div(1'b0, 32'd50, 32'd5, res, n, bn);
        check("midrst_restart_latency", 64'(n), 64'd33);
        check("midrst_restart_res", res, {32'd0, 32'd10});
        release_op();

        // Random sweep with corner operands
        for (int i = 0; i < 60; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            run_div(sgn, a, b, res, n, bn);
            check("rand_latency", 64'(n), (b == 32'd0) ? 64'd1 : 64'd33);
            check("rand_result", res, ref_div(sgn, a, b));
            release_op();
            check("rand_release", 64'(ready), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
